// File: rtl/g_matched_filter.sv
// g_matched_filter: z_k = G_k^H * y for the four candidate matrices, accumulated one G row per beat.
module g_matched_filter #(
   parameter int N     = 16,
   parameter int ACC_W = 2*N+3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    y_in_valid,
   input  logic signed [N-1:0]     y_in_r,
   input  logic signed [N-1:0]     y_in_i,
   input  logic                    G_row_valid,
   input  logic signed [N-1:0]     Ga1_c0_r,
   input  logic signed [N-1:0]     Ga1_c0_i,
   input  logic signed [N-1:0]     Ga1_c1_r,
   input  logic signed [N-1:0]     Ga1_c1_i,
   input  logic signed [N-1:0]     Ga2_c0_r,
   input  logic signed [N-1:0]     Ga2_c0_i,
   input  logic signed [N-1:0]     Ga2_c1_r,
   input  logic signed [N-1:0]     Ga2_c1_i,
   input  logic signed [N-1:0]     Gb1_c0_r,
   input  logic signed [N-1:0]     Gb1_c0_i,
   input  logic signed [N-1:0]     Gb1_c1_r,
   input  logic signed [N-1:0]     Gb1_c1_i,
   input  logic signed [N-1:0]     Gb2_c0_r,
   input  logic signed [N-1:0]     Gb2_c0_i,
   input  logic signed [N-1:0]     Gb2_c1_r,
   input  logic signed [N-1:0]     Gb2_c1_i,
   output logic                    z_valid,
   output logic                    busy,
   output logic                    row_drop,
   output logic signed [ACC_W-1:0] za1_c0_r,
   output logic signed [ACC_W-1:0] za1_c0_i,
   output logic signed [ACC_W-1:0] za1_c1_r,
   output logic signed [ACC_W-1:0] za1_c1_i,
   output logic signed [ACC_W-1:0] za2_c0_r,
   output logic signed [ACC_W-1:0] za2_c0_i,
   output logic signed [ACC_W-1:0] za2_c1_r,
   output logic signed [ACC_W-1:0] za2_c1_i,
   output logic signed [ACC_W-1:0] zb1_c0_r,
   output logic signed [ACC_W-1:0] zb1_c0_i,
   output logic signed [ACC_W-1:0] zb1_c1_r,
   output logic signed [ACC_W-1:0] zb1_c1_i,
   output logic signed [ACC_W-1:0] zb2_c0_r,
   output logic signed [ACC_W-1:0] zb2_c0_i,
   output logic signed [ACC_W-1:0] zb2_c1_r,
   output logic signed [ACC_W-1:0] zb2_c1_i
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD_Y, S_ACC} state_t;
   state_t state, nxt;
   logic [1:0] y_cnt, row_cnt;
   logic signed [N-1:0] y_r [4];
   logic signed [N-1:0] y_i [4];
   logic signed [N-1:0] g_r [8];
   logic signed [N-1:0] g_i [8];
   logic signed [ACC_W-1:0] acc_r [8];
   logic signed [ACC_W-1:0] acc_i [8];
   logic signed [ACC_W-1:0] t_r [8];
   logic signed [ACC_W-1:0] t_i [8];
   logic signed [ACC_W-1:0] z_r [8];
   logic signed [ACC_W-1:0] z_i [8];
   logic y_wr, row_acc, acc_clr;
   // column slot index is k*2+c, matrices ordered a1, a2, b1, b2
   assign g_r = '{Ga1_c0_r, Ga1_c1_r, Ga2_c0_r, Ga2_c1_r, Gb1_c0_r, Gb1_c1_r, Gb2_c0_r, Gb2_c1_r};
   assign g_i = '{Ga1_c0_i, Ga1_c1_i, Ga2_c0_i, Ga2_c1_i, Gb1_c0_i, Gb1_c1_i, Gb2_c0_i, Gb2_c1_i};
   assign za1_c0_r = z_r[0]; assign za1_c0_i = z_i[0];
   assign za1_c1_r = z_r[1]; assign za1_c1_i = z_i[1];
   assign za2_c0_r = z_r[2]; assign za2_c0_i = z_i[2];
   assign za2_c1_r = z_r[3]; assign za2_c1_i = z_i[3];
   assign zb1_c0_r = z_r[4]; assign zb1_c0_i = z_i[4];
   assign zb1_c1_r = z_r[5]; assign zb1_c1_i = z_i[5];
   assign zb2_c0_r = z_r[6]; assign zb2_c0_i = z_i[6];
   assign zb2_c1_r = z_r[7]; assign zb2_c1_i = z_i[7];
   assign busy    = state != S_IDLE;
   assign y_wr    = y_in_valid && state != S_ACC;
   assign row_acc = G_row_valid && state == S_ACC;
   assign acc_clr = state == S_LOAD_Y && y_in_valid && y_cnt == 2'd3;

   function automatic logic signed [ACC_W-1:0] mul(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
      return ACC_W'(a) * ACC_W'(b);
   endfunction

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         t_r[k] = mul(g_r[k], y_r[row_cnt]) + mul(g_i[k], y_i[row_cnt]);
         t_i[k] = mul(g_r[k], y_i[row_cnt]) - mul(g_i[k], y_r[row_cnt]);
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:   if (y_in_valid) nxt = S_LOAD_Y;
         S_LOAD_Y: if (y_in_valid && y_cnt == 2'd3) nxt = S_ACC;
         S_ACC:    if (G_row_valid && row_cnt == 2'd3) nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) state <= rst ? S_IDLE : nxt;

   // y storage is not reset: it is always rewritten before the next accumulation
   always_ff @(posedge clk) begin
      if (!rst && y_wr) begin
         y_r[y_cnt] <= y_in_r;
         y_i[y_cnt] <= y_in_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_cnt    <= '0;
         row_cnt  <= '0;
         z_valid  <= 1'b0;
         row_drop <= 1'b0;
         for (int k = 0; k < 8; k++) begin
            acc_r[k] <= '0;
            acc_i[k] <= '0;
            z_r[k]   <= '0;
            z_i[k]   <= '0;
         end
      end else begin
         z_valid  <= row_acc && row_cnt == 2'd3;
         row_drop <= G_row_valid && state != S_ACC;
         if (y_wr) y_cnt <= y_cnt + 2'd1;
         if (row_acc) row_cnt <= row_cnt + 2'd1;
         for (int k = 0; k < 8; k++) begin
            if (acc_clr) begin
               acc_r[k] <= '0;
               acc_i[k] <= '0;
            end else if (row_acc) begin
               acc_r[k] <= acc_r[k] + t_r[k];
               acc_i[k] <= acc_i[k] + t_i[k];
            end
            if (row_acc && row_cnt == 2'd3) begin
               z_r[k] <= acc_r[k] + t_r[k];
               z_i[k] <= acc_i[k] + t_i[k];
            end
         end
      end
   end
endmodule

// File: tb/tb_g_matched_filter.sv
// tb_g_matched_filter: randomized scoreboard bench; expected z values come from a plain-arithmetic matrix model.
module tb_g_matched_filter;
   localparam int N = 16;
   localparam int W = 2*N+3;

   logic clk = 1'b0, rst = 1'b1;
   logic y_in_valid = 1'b0, G_row_valid = 1'b0;
   logic signed [N-1:0] y_in_r = '0, y_in_i = '0;
   logic signed [N-1:0] g_r_d [8];
   logic signed [N-1:0] g_i_d [8];
   logic z_valid, busy, row_drop;
   logic signed [W-1:0] zr [8];
   logic signed [W-1:0] zi [8];

   int total = 0, bad = 0, zv_count = 0;
   longint exp_q [$];
   logic last_row = 1'b0, zv_exp = 1'b0;
   int yr [4], yi [4];
   int gr [4][8], gi [4][8];

   always #5 clk = ~clk;

   g_matched_filter #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .y_in_valid(y_in_valid), .y_in_r(y_in_r), .y_in_i(y_in_i),
      .G_row_valid(G_row_valid),
      .Ga1_c0_r(g_r_d[0]), .Ga1_c0_i(g_i_d[0]), .Ga1_c1_r(g_r_d[1]), .Ga1_c1_i(g_i_d[1]),
      .Ga2_c0_r(g_r_d[2]), .Ga2_c0_i(g_i_d[2]), .Ga2_c1_r(g_r_d[3]), .Ga2_c1_i(g_i_d[3]),
      .Gb1_c0_r(g_r_d[4]), .Gb1_c0_i(g_i_d[4]), .Gb1_c1_r(g_r_d[5]), .Gb1_c1_i(g_i_d[5]),
      .Gb2_c0_r(g_r_d[6]), .Gb2_c0_i(g_i_d[6]), .Gb2_c1_r(g_r_d[7]), .Gb2_c1_i(g_i_d[7]),
      .z_valid(z_valid), .busy(busy), .row_drop(row_drop),
      .za1_c0_r(zr[0]), .za1_c0_i(zi[0]), .za1_c1_r(zr[1]), .za1_c1_i(zi[1]),
      .za2_c0_r(zr[2]), .za2_c0_i(zi[2]), .za2_c1_r(zr[3]), .za2_c1_i(zi[3]),
      .zb1_c0_r(zr[4]), .zb1_c0_i(zi[4]), .zb1_c1_r(zr[5]), .zb1_c1_i(zi[5]),
      .zb2_c0_r(zr[6]), .zb2_c0_i(zi[6]), .zb2_c1_r(zr[7]), .zb2_c1_i(zi[7])
   );

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // z_valid is expected exactly one cycle after the 4th accepted row
   always @(posedge clk) zv_exp <= last_row && G_row_valid && !rst;

   always @(negedge clk) begin
      if (z_valid || zv_exp) check("z_valid_timing", longint'(z_valid), longint'(zv_exp));
      if (z_valid) begin
         zv_count++;
         if (exp_q.size() < 16) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty actual=z_valid required=no_pulse");
         end else begin
            for (int k = 0; k < 8; k++) begin
               check($sformatf("z%0d_r", k), longint'(zr[k]), exp_q.pop_front());
               check($sformatf("z%0d_i", k), longint'(zi[k]), exp_q.pop_front());
            end
         end
      end
   end

   // z_k[c] = sum_i conj(G_k[i][c]) * y[i]
   task automatic push_exp();
      for (int k = 0; k < 8; k++) begin
         longint sr, si;
         sr = 0;
         si = 0;
         for (int i = 0; i < 4; i++) begin
            sr += longint'(gr[i][k]) * yr[i] + longint'(gi[i][k]) * yi[i];
            si += longint'(gr[i][k]) * yi[i] - longint'(gi[i][k]) * yr[i];
         end
         exp_q.push_back(sr);
         exp_q.push_back(si);
      end
   endtask

   task automatic rand_data(input int lim);
      for (int i = 0; i < 4; i++) begin
         yr[i] = int'($urandom_range(0, 2*lim-1)) - lim;
         yi[i] = int'($urandom_range(0, 2*lim-1)) - lim;
         for (int k = 0; k < 8; k++) begin
            gr[i][k] = int'($urandom_range(0, 65535)) - 32768;
            gi[i][k] = int'($urandom_range(0, 65535)) - 32768;
         end
      end
   endtask

   task automatic send_y(input int first, input int last, input int gap, input bit chk);
      for (int i = first; i <= last; i++) begin
         y_in_valid = 1'b1;
         y_in_r = N'(yr[i]);
         y_in_i = N'(yi[i]);
         @(posedge clk); #1;
         y_in_valid = 1'b0;
         if (i < 3) repeat (gap) begin
            @(posedge clk); #1;
            if (chk) check("busy_gap_y", longint'(busy), 1);
         end
      end
   endtask

   task automatic send_rows(input int gap, input bit chk, input int nrows, input bit junk);
      if (nrows == 4) push_exp();
      for (int i = 0; i < nrows; i++) begin
         for (int k = 0; k < 8; k++) begin
            g_r_d[k] = N'(gr[i][k]);
            g_i_d[k] = N'(gi[i][k]);
         end
         G_row_valid = 1'b1;
         last_row = (i == 3);
         if (junk && i == 1) begin
            y_in_valid = 1'b1;
            y_in_r = N'($urandom);
            y_in_i = N'($urandom);
         end
         @(posedge clk); #1;
         G_row_valid = 1'b0;
         last_row = 1'b0;
         y_in_valid = 1'b0;
         if (i < nrows - 1) repeat (gap) begin
            @(posedge clk); #1;
            if (chk) check("busy_gap_row", longint'(busy), 1);
         end
      end
   endtask

   task automatic sanity_data();
      int c0r [4] = '{2, 4, 2, 4};
      int c0i [4] = '{3, -1, 3, -1};
      int c1r [4] = '{4, -2, -4, 2};
      int c1i [4] = '{-1, -3, 1, 3};
      yr = '{1, 0, 0, 0};
      yi = '{0, 0, 0, 0};
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 8; k++) begin
            gr[i][k] = 0;
            gi[i][k] = 0;
         end
      for (int m = 0; m < 4; m++) begin
         gr[0][2*m] = c0r[m];   gi[0][2*m] = c0i[m];
         gr[0][2*m+1] = c1r[m]; gi[0][2*m+1] = c1i[m];
      end
   endtask

   task automatic check_z_zero(input string tag);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("%s_z%0d_r", tag, k), longint'(zr[k]), 0);
         check($sformatf("%s_z%0d_i", tag, k), longint'(zi[k]), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int zv0;
      for (int k = 0; k < 8; k++) begin
         g_r_d[k] = '0;
         g_i_d[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", longint'(busy), 0);
      check("rst_z_valid", longint'(z_valid), 0);
      check("rst_row_drop", longint'(row_drop), 0);
      check_z_zero("rst");
      rst = 1'b0;
      @(posedge clk); #1;

      // sanity: single non-zero row
      sanity_data();
      send_y(0, 3, 0, 0);
      send_rows(0, 0, 4, 0);
      repeat (2) @(posedge clk);
      #1;
      check("sanity_za1_c0_r", longint'(zr[0]), 2);
      check("sanity_za1_c0_i", longint'(zi[0]), -3);
      check("sanity_zb2_c1_r", longint'(zr[7]), 2);
      check("sanity_zb2_c1_i", longint'(zi[7]), -3);

      // extremes: worst-case magnitude must not wrap
      for (int i = 0; i < 4; i++) begin
         yr[i] = -32768;
         yi[i] = -32768;
         for (int k = 0; k < 8; k++) begin
            gr[i][k] = -32768;
            gi[i][k] = -32768;
         end
      end
      send_y(0, 3, 0, 0);
      send_rows(0, 0, 4, 0);
      repeat (2) @(posedge clk);
      #1;
      check("extreme_z_r", longint'(zr[5]), 64'sd8589934592);
      check("extreme_z_i", longint'(zi[5]), 0);

      // gapped stream
      sanity_data();
      zv0 = zv_count;
      send_y(0, 3, 2, 1);
      send_rows(2, 1, 4, 0);
      repeat (3) @(posedge clk);
      #1;
      check("gapped_zv_pulses", longint'(zv_count - zv0), 1);
      check("gapped_busy_end", longint'(busy), 0);

      // early row, plus a row coinciding with the last y beat
      rand_data(32768);
      send_y(0, 1, 0, 0);
      G_row_valid = 1'b1;
      @(posedge clk); #1;
      G_row_valid = 1'b0;
      @(negedge clk);
      check("early_row_drop", longint'(row_drop), 1);
      check("early_busy", longint'(busy), 1);
      send_y(2, 2, 0, 0);
      y_in_valid = 1'b1;
      y_in_r = N'(yr[3]);
      y_in_i = N'(yi[3]);
      G_row_valid = 1'b1;
      @(posedge clk); #1;
      y_in_valid = 1'b0;
      G_row_valid = 1'b0;
      @(negedge clk);
      check("last_y_row_drop", longint'(row_drop), 1);
      send_rows(0, 0, 4, 0);
      repeat (2) @(posedge clk);
      #1;

      // reset mid-accumulation
      rand_data(32768);
      send_y(0, 3, 0, 0);
      send_rows(0, 0, 2, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_busy", longint'(busy), 0);
      check_z_zero("midrst");
      rand_data(32768);
      send_y(0, 3, 0, 0);
      send_rows(0, 0, 4, 0);
      repeat (2) @(posedge clk);
      #1;

      // back-to-back: second y[0] lands in the z_valid cycle, y doubled
      rand_data(16384);
      send_y(0, 3, 0, 0);
      send_rows(0, 0, 4, 0);
      for (int i = 0; i < 4; i++) begin
         yr[i] = 2 * yr[i];
         yi[i] = 2 * yi[i];
      end
      send_y(0, 3, 0, 0);
      send_rows(0, 0, 4, 0);
      repeat (2) @(posedge clk);
      #1;

      // random transactions, with stray y beats during accumulation
      for (int t = 0; t < 6; t++) begin
         rand_data(32768);
         send_y(0, 3, int'($urandom_range(0, 2)), 1);
         send_rows(int'($urandom_range(0, 2)), 1, 4, 1'(t % 2));
      end
      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", longint'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/g_matched_filter.md
# g_matched_filter

Computes the matched-filter outputs z_k = G_kᴴ·y for the four candidate matrices G_a1, G_a2, G_b1 and G_b2 produced by g_matrix_calculator, for one received 4-element complex vector y. It sits directly downstream of g_matrix_calculator and consumes its row stream unchanged. It loads y first, then accumulates one row term per G_row_valid beat. After the 4th row it emits 8 full-precision complex results, two columns per matrix, to the detection stage.

## Interface
Parameters:
- N, 16, signed width of every input real/imag component
- ACC_W, 2*N+3, output width; fixed by the arithmetic, must not be overridden

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high, one clock domain
- y_in_valid  in  1  one y sample per high cycle; index order 0..3
- y_in_r, y_in_i  in  N  signed y sample
- G_row_valid  in  1  one G row (index i = 0..3) per high cycle
- Ga1_c0_r … Gb2_c1_i  in  N each  the 16 signed row components, named exactly as the g_matrix_calculator outputs
- z_valid  out  1  single-cycle pulse: all z outputs updated
- busy  out  1  high whenever state ≠ S_IDLE
- row_drop  out  1  single-cycle pulse: a G row arrived outside S_ACC and was discarded
- za1_c0_r … zb2_c1_i  out  ACC_W each  16 signed results, z{k}_c{c} = Σ_i conj(G_k[i][c])·y[i]

## Operation
- States:
  - S_IDLE: y_in_valid writes y[0] and moves to S_LOAD_Y.
  - S_LOAD_Y: each y_in_valid writes y[y_cnt]. The beat with y_cnt = 3 moves to S_ACC.
  - S_ACC: each G_row_valid adds row i = row_cnt into the 16 accumulators. The beat with row_cnt = 3 registers the final sums, pulses z_valid and returns to S_IDLE.
- Gaps between y beats or between G rows are allowed; only valid cycles are counted.
- Term per element: conj(g)·y = (gr·yr + gi·yi) + j(gr·yi − gi·yr).
  - Products are N×N signed → 2N bits.
  - All sums are sign-extended to ACC_W.
  - No rounding, saturation or truncation; ACC_W covers the worst case (4·2^(2N−1) = 2^(2N+1)).
- Accumulators clear on the transition into S_ACC. The y RAM persists until overwritten.
- y_in_valid in S_ACC is ignored: y is not modified and no flag is raised.
- G_row_valid in S_IDLE or S_LOAD_Y: the row is discarded, row_drop pulses, and state and counters are unchanged.
- A simultaneous y_in_valid and G_row_valid in S_LOAD_Y on the last y beat: the y beat is accepted and the row is dropped (row_drop = 1).
- z outputs hold their values until the next z_valid.

## Timing
- Reset: on a rst-high edge:
  - state = S_IDLE; y_cnt = row_cnt = 0; accumulators = 0.
  - All z outputs = 0; z_valid = busy = row_drop = 0.
  - rst overrides all inputs in the same cycle.
  - Reset mid-transaction discards partial y and partial sums.
- busy rises the cycle after the first y beat and falls the cycle after the 4th row is sampled.
- Latency: z_valid = 1 and z outputs valid in the cycle immediately after the cycle in which the 4th G_row_valid is high.
  - Back-to-back rows give z_valid 4 cycles after the first G_row_valid cycle.
- The next y_in_valid may arrive in the same cycle that z_valid is high; it is accepted as the new y[0].
- A G row is accepted in the cycle after the 4th y beat at the earliest.
- row_drop is registered: high the cycle after the offending beat.

## Test plan
- Single-row sanity (N=16):
  - Stimulus: y = [1, 0, 0, 0]; row 0 Ga1 = (2+3j, 4−1j), Ga2 = (4−1j, −2−3j), Gb1 = (2+3j, −4+1j), Gb2 = (4−1j, 2+3j); rows 1–3 = 0.
  - Required: za1 = (2−3j, 4+1j), za2 = (4+1j, −2+3j), zb1 = (2−3j, −4−1j), zb2 = (4+1j, 2−3j), with z_valid one cycle after row 3.
- Extremes: every G component = −32768 and every y = −32768−32768j, 4 rows → every z real = 2^33 (8589934592), every z imag = 0, with no wrap at ACC_W = 35.
- Gapped stream: the same data as the sanity case with 2 idle cycles between each y beat and each G row → identical results; busy stays high throughout; exactly one z_valid pulse.
- Early row: G_row_valid after only 2 y beats → row_drop pulses next cycle; y_cnt is unchanged; after the remaining y beats and 4 rows, results equal the no-drop case.
- Reset mid-operation: rst after 2 accepted rows → next cycle busy = 0 and all z outputs = 0; a fresh full transaction then gives the correct results and no stale terms.
- Back-to-back transactions: the second y[0] arrives in the z_valid cycle, with y2 = 2·y1 and the same rows → the second z_valid gives exactly twice the first results.
